countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised game countdown timer for the whack-a-mole game. It divides the system clock by a prescaler to form count ticks and decrements a loadable counter once per tick. It signals expiry with a level and a one-cycle pulse. It supports start, pause, load and optional auto-reload, and it feeds the score/round controller and the seven-segment display driver in place of the fixed five-second countdown.

## Interface
- `CNT_W`, 32, width of the count value.
- `START_VAL`, 5, value of `countout` and of the reload register after reset; must be < 2^CNT_W.
- `PRESCALE`, 100_000_000, clk cycles per count tick; must be >= 1; prescaler width is max(1, $clog2(PRESCALE)).
- `AUTO_RELOAD`, 0, 1 = reload on expiry and keep running; 0 = stop in DONE.
- Ports, in order name, direction, width, meaning:
- `clk`, input, 1, system clock, rising edge.
- `reset`, input, 1, reset; one clock; reset is synchronous and active-high.
- `start`, input, 1, begin or resume counting (sampled each cycle).
- `pause`, input, 1, level; hold count while high (see Configuration).
- `load`, input, 1, load `load_val` into counter and reload register.
- `load_val`, input, CNT_W, value captured on `load`.
- `countout`, output, CNT_W, current remaining count (registered).
- `tick`, output, 1, one-cycle pulse coincident with each decrement.
- `running`, output, 1, high in RUN.
- `done`, output, 1, level, high in DONE.
- `done_pulse`, output, 1, one-cycle pulse on every expiry.

## Operation
- States: IDLE, RUN, PAUSED, DONE; 2-bit state register.
- Reset: state=IDLE, `countout`=START_VAL, reload reg=START_VAL, prescaler=0, `tick`=`done_pulse`=`running`=`done`=0.
- Priority per cycle: reset > load > start > pause > prescaler.
- `load` in any state: `countout`<=`load_val`, reload reg<=`load_val`, prescaler<=0, state<=IDLE. A `start` in the same cycle is ignored.
- IDLE + `start`: if `countout`!=0, go to RUN with prescaler<=0. If `countout`==0, go directly to expiry handling (DONE, or RUN with reload when AUTO_RELOAD=1) and pulse `done_pulse`.
- RUN: prescaler increments each cycle. At prescaler==PRESCALE-1: prescaler<=0, `tick`<=1, `countout`<=`countout`-1.
- Expiry: a decrement from 1 to 0 pulses `done_pulse`.
  - AUTO_RELOAD=0: state<=DONE and `countout` holds at 0.
  - AUTO_RELOAD=1: `countout`<=reload reg (not 0), stay in RUN, `done` never asserts. A reload value of 0 expires again on the next tick.
- RUN + `pause`: go to PAUSED; prescaler and `countout` hold. If pause coincides with the terminal prescaler count, pause wins: no decrement, and the prescaler stays at PRESCALE-1.
- PAUSED + !`pause`: return to RUN. `start` does not override a held `pause`.
- DONE + `start`: `countout`<=reload reg, prescaler<=0, state<=RUN. In DONE, `countout`=0 and `done`=1.
- `start` in RUN or PAUSED has no effect. The counter never wraps below 0.

## Timing
- All outputs are registered. `running`/`done` follow state with zero extra delay (decoded from the state register).
- `tick` and `done_pulse` are high for exactly one cycle, in the same cycle the new `countout` is visible.
- Start sampled at edge E0: first decrement visible after edge E0+PRESCALE. Expiry from N is visible after edge E0+N*PRESCALE, plus the number of paused cycles.
- PRESCALE=1: decrement every cycle while in RUN.
- `load` takes effect at the next edge; `countout` shows `load_val` one cycle after `load` is sampled.
- Reset mid-run: the next cycle is exactly the reset state, and no pulses are emitted.

## Configuration
- `COUNTDOWN_PAUSE_EN` defined: pause logic and the PAUSED state are compiled in, behaving as above.
- Not defined: the `pause` port exists but is ignored, PAUSED is unreachable, and RUN counts continuously.

## Test plan
- Reset, PRESCALE=4, START_VAL=5; pulse start at E0 -> `countout` 4,3,2,1,0 after edges E0+4,+8,+12,+16,+20, each with `tick`=1. At E0+20, `done_pulse`=1 for 1 cycle, then `done`=1 and `running`=0.
- From DONE, load 3 then start -> `countout`=3 one cycle after load, `done`=0. Expiry 12 cycles after the start edge.
- `COUNTDOWN_PAUSE_EN` defined, PRESCALE=4: hold pause 10 cycles while at 3 with prescaler=3 -> no decrement during pause. `countout`=2 on the first edge after pause drops.
- AUTO_RELOAD=1, START_VAL=2, PRESCALE=1 -> `countout` 1,0→2 sequence shows 1 then 2 with `done_pulse` every 2 cycles, and `done` stays 0.
- Load 0 then start -> `done_pulse` 1 cycle later and DONE, with no `tick`.
- Assert `reset` mid-RUN at `countout`=2 -> `countout`=5, state IDLE, all flags 0 the next cycle. Same-cycle `load`+`start` -> IDLE with `load_val`.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//
// Game countdown timer. A prescaler divides clk into count ticks; each tick
// decrements a loadable counter. Expiry is reported as a level (done) and a
// one-cycle pulse (done_pulse). Supports start, pause, load and optional
// auto-reload on expiry.
//
// Build option:
//   COUNTDOWN_PAUSE_EN  - when defined, pause holds the count (PAUSED state).
//                         When undefined, the pause port is ignored.
//
// Parameters:
//   CNT_W       - width of the count value
//   START_VAL   - countout and reload value after reset
//   PRESCALE    - clk cycles per count tick (>= 1)
//   AUTO_RELOAD - 1: reload and keep running on expiry, 0: stop in DONE
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin or resume counting
//   pause       in   hold the count while high
//   load        in   capture load_val into counter and reload register
//   load_val    in   value captured on load
//   countout    out  remaining count (registered)
//   tick        out  one-cycle pulse with each decrement
//   running     out  high in RUN
//   done        out  high in DONE
//   done_pulse  out  one-cycle pulse on every expiry

module countdown_timer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned START_VAL   = 5,
  parameter int unsigned PRESCALE    = 100_000_000,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] countout,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             done_pulse
);

  localparam int unsigned      PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] START     = CNT_W'(START_VAL);
  localparam bit               RELOAD_EN = (AUTO_RELOAD != 0);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] reload_q;
  logic [PW-1:0]    presc_q;

  logic pause_act;

`ifdef COUNTDOWN_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
  logic unused_pause;
  assign unused_pause = pause;
`endif

  // Expiry target: reload and keep running, or park at zero in DONE.
  state_e           exp_state;
  logic [CNT_W-1:0] exp_cnt;

  // Result of one counting cycle (shared by RUN and the PAUSED->RUN resume).
  logic             step_term;
  logic             step_expire;
  state_e           step_state;
  logic [CNT_W-1:0] step_cnt;
  logic [PW-1:0]    step_presc;

  always_comb begin
    exp_state   = RELOAD_EN ? StRun : StDone;
    exp_cnt     = RELOAD_EN ? reload_q : '0;

    step_term   = (presc_q == PS_LAST);
    // A count of 0 in RUN only happens with a zero reload value; treat it
    // as an immediate re-expiry instead of wrapping.
    step_expire = step_term && (countout <= CNT_W'(1));
    step_state  = step_expire ? exp_state : StRun;
    step_presc  = step_term ? '0 : presc_q + PW'(1);
    if (!step_term) begin
      step_cnt = countout;
    end else if (step_expire) begin
      step_cnt = exp_cnt;
    end else begin
      step_cnt = countout - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    tick       <= 1'b0;
    done_pulse <= 1'b0;
    if (reset) begin
      state_q  <= StIdle;
      countout <= START;
      reload_q <= START;
      presc_q  <= '0;
    end else if (load) begin
      countout <= load_val;
      reload_q <= load_val;
      presc_q  <= '0;
      state_q  <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            presc_q <= '0;
            if (countout != '0) begin
              state_q <= StRun;
            end else begin
              state_q    <= exp_state;
              countout   <= exp_cnt;
              done_pulse <= 1'b1;
            end
          end
        end
        StRun: begin
          // Pause wins over a terminal prescaler count: nothing advances.
          if (pause_act) begin
            state_q <= StPaused;
          end else begin
            state_q    <= step_state;
            countout   <= step_cnt;
            presc_q    <= step_presc;
            tick       <= step_term;
            done_pulse <= step_expire;
          end
        end
        StPaused: begin
          // Resume and count in the same cycle so only the paused cycles are lost.
          if (!pause_act) begin
            state_q    <= step_state;
            countout   <= step_cnt;
            presc_q    <= step_presc;
            tick       <= step_term;
            done_pulse <= step_expire;
          end
        end
        StDone: begin
          if (start) begin
            countout <= reload_q;
            presc_q  <= '0;
            state_q  <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running = (state_q == StRun);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        pause;
  logic        load;
  logic [31:0] load_val;
  logic [31:0] countout;
  logic        tick;
  logic        running;
  logic        done;
  logic        done_pulse;

  logic        start1;
  logic        pause1;
  logic        load1;
  logic [31:0] load_val1;
  logic [31:0] countout1;
  logic        tick1;
  logic        running1;
  logic        done1;
  logic        done_pulse1;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(
    .CNT_W      (32),
    .START_VAL  (5),
    .PRESCALE   (4),
    .AUTO_RELOAD(0)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .load      (load),
    .load_val  (load_val),
    .countout  (countout),
    .tick      (tick),
    .running   (running),
    .done      (done),
    .done_pulse(done_pulse)
  );

  countdown_timer #(
    .CNT_W      (32),
    .START_VAL  (2),
    .PRESCALE   (1),
    .AUTO_RELOAD(1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .pause     (pause1),
    .load      (load1),
    .load_val  (load_val1),
    .countout  (countout1),
    .tick      (tick1),
    .running   (running1),
    .done      (done1),
    .done_pulse(done_pulse1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        rst;
    logic        st;
    logic        pa;
    logic        ld;
    logic [31:0] lv;
    logic [31:0] e_cnt;
    logic        e_tick;
    logic        e_run;
    logic        e_done;
    logic        e_dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int unsigned cyc, logic rst, logic st, logic pa, logic ld,
                              logic [31:0] lv, logic [31:0] cnt, logic tk, logic run,
                              logic dn, logic dp);
    vec_t v;
    v.cyc = cyc; v.rst = rst; v.st = st; v.pa = pa; v.ld = ld; v.lv = lv;
    v.e_cnt = cnt; v.e_tick = tk; v.e_run = run; v.e_done = dn; v.e_dp = dp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [31:0] cnt, input logic tk, input logic run,
                      input logic dn, input logic dp);
    chk({tag, " countout"},   countout1,   cnt);
    chk({tag, " tick"},       tick1,       {31'd0, tk});
    chk({tag, " running"},    running1,    {31'd0, run});
    chk({tag, " done"},       done1,       {31'd0, dn});
    chk({tag, " done_pulse"}, done_pulse1, {31'd0, dp});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0; load_val = '0;
    start1 = 1'b0; pause1 = 1'b0; load1 = 1'b0; load_val1 = '0;

    //                 cyc rst st pa ld lv  cnt tk run dn dp
    vecs.push_back(mk(1,  1, 0, 0, 0, 0,  5, 0, 0, 0, 0));  // reset state
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  5, 0, 1, 0, 0));  // start (E0)
    vecs.push_back(mk(3,  0, 0, 0, 0, 0,  5, 0, 1, 0, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  4, 1, 1, 0, 0));  // E0+4
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  4, 0, 1, 0, 0));
    vecs.push_back(mk(3,  0, 0, 0, 0, 0,  3, 1, 1, 0, 0));  // E0+8
    vecs.push_back(mk(4,  0, 0, 0, 0, 0,  2, 1, 1, 0, 0));  // E0+12
    vecs.push_back(mk(4,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0));  // E0+16
    vecs.push_back(mk(3,  0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  0, 1, 0, 1, 1));  // E0+20 expiry
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0));  // pulse is one cycle
    vecs.push_back(mk(1,  0, 0, 0, 1, 3,  3, 0, 0, 0, 0));  // load 3 from DONE
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  3, 0, 1, 0, 0));  // start
    vecs.push_back(mk(11, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  0, 1, 0, 1, 1));  // 12 cycles after start
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  3, 0, 1, 0, 0));  // DONE+start reloads 3
    vecs.push_back(mk(4,  0, 0, 0, 0, 0,  2, 1, 1, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  2, 0, 1, 0, 0));  // start in RUN ignored
    vecs.push_back(mk(1,  1, 0, 0, 0, 0,  5, 0, 0, 0, 0));  // reset mid-run at 2
    vecs.push_back(mk(1,  0, 1, 0, 1, 0,  0, 0, 0, 0, 0));  // load 0 + start -> IDLE
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  0, 0, 0, 1, 1));  // start at 0: expiry, no tick
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 0, 0, 1, 3,  3, 0, 0, 0, 0));  // load 3
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  3, 0, 1, 0, 0));  // start
    vecs.push_back(mk(3,  0, 0, 0, 0, 0,  3, 0, 1, 0, 0));  // prescaler now at 3
`ifdef COUNTDOWN_PAUSE_EN
    vecs.push_back(mk(1,  0, 0, 1, 0, 0,  3, 0, 0, 0, 0));  // pause beats terminal count
    vecs.push_back(mk(9,  0, 1, 1, 0, 0,  3, 0, 0, 0, 0));  // held pause, start ignored
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  2, 1, 1, 0, 0));  // first edge after release
    vecs.push_back(mk(4,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0));
    vecs.push_back(mk(4,  0, 0, 0, 0, 0,  0, 1, 0, 1, 1));
`else
    vecs.push_back(mk(1,  0, 0, 1, 0, 0,  2, 1, 1, 0, 0));  // pause ignored
    vecs.push_back(mk(9,  0, 0, 1, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
`endif

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      start    = vecs[i].st;
      pause    = vecs[i].pa;
      load     = vecs[i].ld;
      load_val = vecs[i].lv;
      repeat (vecs[i].cyc) @(posedge clk);
      #1;
      chk($sformatf("v%0d countout", i),   countout,   vecs[i].e_cnt);
      chk($sformatf("v%0d tick", i),       tick,       {31'd0, vecs[i].e_tick});
      chk($sformatf("v%0d running", i),    running,    {31'd0, vecs[i].e_run});
      chk($sformatf("v%0d done", i),       done,       {31'd0, vecs[i].e_done});
      chk($sformatf("v%0d done_pulse", i), done_pulse, {31'd0, vecs[i].e_dp});
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;

    // Auto-reload, PRESCALE=1, START_VAL=2: 1,2,1,2... with done_pulse on each 2.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk1("ar start", 2, 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("ar k%0d", k), ((k % 2) == 1) ? 32'd1 : 32'd2, 1'b1, 1'b1, 1'b0,
           ((k % 2) == 0));
    end

    // Zero reload value: starts straight into an expiry, then re-expires every tick.
    load1 = 1'b1; load_val1 = 32'd0;
    @(posedge clk); #1;
    load1 = 1'b0;
    chk1("ar load0", 0, 0, 0, 0, 0);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk1("ar start0", 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    chk1("ar reexpire", 0, 1, 1, 0, 1);
    load1 = 1'b1; load_val1 = 32'd3;
    @(posedge clk); #1;
    load1 = 1'b0;
    chk1("ar load3", 3, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
